mult_datapath: RTL

Arithmetic datapath for the sequential 8x8 multiplier, directly downstream of the multiplier control FSM. It consumes input_sel, shift_sel, clk_ena, sclr_n and done from the FSM. It computes one 4x4 partial product per enabled cycle, shifts it, and accumulates it into a 16-bit product. It also generates the 2-bit count that feeds back to the FSM.

---
 rtl/mult_datapath.sv | 98 +++++++++
 1 files changed

// File: rtl/mult_datapath.sv
// Datapath for the sequential 8x8 multiplier: one 4x4 partial product per enabled cycle, shifted and accumulated.
// Optional build macro MULT_OVF_CHK_EN enables the sticky carry-out / illegal-shift flag on ovf_err.
module mult_datapath #(
    parameter int OP_W  = 8,
    parameter int NIB_W = OP_W / 2
) (
    input  logic              clk,
    input  logic              reset_a,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    input  logic [1:0]        input_sel,
    input  logic [1:0]        shift_sel,
    input  logic              clk_ena,
    input  logic              sclr_n,
    input  logic              done,
    output logic [1:0]        count,
    output logic [2*OP_W-1:0] product8x8,
    output logic              result_valid,
    output logic              ovf_err
);

    logic [OP_W-1:0]   opa;
    logic [OP_W-1:0]   opb;
    logic [2*OP_W-1:0] acc;
    logic [1:0]        cnt;
    logic              rv;
    logic [NIB_W-1:0]  nib_a;
    logic [NIB_W-1:0]  nib_b;
    logic [OP_W-1:0]   pp;
    logic [2*OP_W-1:0] pp_sh;
    logic              clear_cycle;
    logic              acc_cycle;

    assign clear_cycle = clk_ena && !sclr_n;
    assign acc_cycle   = clk_ena && sclr_n;

    always_comb begin
        nib_a = input_sel[0] ? opa[OP_W-1:NIB_W] : opa[NIB_W-1:0];
        nib_b = input_sel[1] ? opb[OP_W-1:NIB_W] : opb[NIB_W-1:0];
        pp    = {{NIB_W{1'b0}}, nib_a} * {{NIB_W{1'b0}}, nib_b};
        // shift_sel 11 is illegal and falls through to no shift
        case (shift_sel)
            2'b01:   pp_sh = {{OP_W{1'b0}}, pp} << 4;
            2'b10:   pp_sh = {{OP_W{1'b0}}, pp} << 8;
            default: pp_sh = {{OP_W{1'b0}}, pp};
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            opa <= '0;
            opb <= '0;
            acc <= '0;
            cnt <= '0;
            rv  <= 1'b0;
        end else begin
            if (clear_cycle) begin
                opa <= dataa;
                opb <= datab;
                acc <= '0;
                cnt <= '0;
            end else if (acc_cycle) begin
                acc <= acc + pp_sh;
                cnt <= cnt + 2'd1;
            end
            // result_valid ignores clk_ena, but a clear in the same cycle beats done
            if (clear_cycle)
                rv <= 1'b0;
            else if (done)
                rv <= 1'b1;
        end
    end

`ifdef MULT_OVF_CHK_EN
    logic [2*OP_W:0] sum_ext;
    logic            ovf_q;

    assign sum_ext = {1'b0, acc} + {1'b0, pp_sh};

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            ovf_q <= 1'b0;
        else if (clear_cycle)
            ovf_q <= 1'b0;
        else if (acc_cycle && (sum_ext[2*OP_W] || shift_sel == 2'b11))
            ovf_q <= 1'b1;
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

    assign count        = cnt;
    assign product8x8   = acc;
    assign result_valid = rv;

endmodule
